// File: rtl/ram_arbiter.sv
// Three-port round-robin arbiter (fetch/data/debug) for a single-port RAM, with debug priority and lock.
// Latency: combinational grant, RAM strobe at T+1, tagged read data at T+2; losers hold req until granted.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 10
`endif

module ram_arbiter #(
    parameter int ADDR_BITS    = `RAM_ADDR_BITS,
    parameter bit DBG_PRIORITY = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             req,
    input  logic [2:0]             we,
    input  logic [3*ADDR_BITS-1:0] addr,
    input  logic [11:0]            byteen,
    input  logic [95:0]            wrdata,
    input  logic                   dbg_lock,
    output logic [2:0]             gnt,
    output logic [2:0]             rd_valid,
    output logic [31:0]            rd_data,
    output logic [ADDR_BITS-1:0]   ram_addr,
    output logic [3:0]             ram_byteen,
    output logic [31:0]            ram_wrdata,
    output logic                   ram_rden,
    output logic                   ram_wren,
    input  logic [31:0]            ram_rddata
);

    logic [1:0]           last_q;
    logic                 locked_q;
    logic [1:0]           c0, c1, c2;
    logic                 gnt_any;
    logic [1:0]           gnt_idx;
    logic                 sel_we;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [3:0]           sel_byteen;
    logic [31:0]          sel_wrdata;
    logic                 t1_vld, t2_vld;
    logic [1:0]           t1_port, t2_port;

    // Round-robin search order starts just after the last granted port.
    always_comb begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
        case (last_q)
            2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        gnt     = 3'b000;
        if (!rst) begin
            if (locked_q || (DBG_PRIORITY && req[2])) begin
                if (req[2]) begin
                    gnt_any = 1'b1;
                    gnt_idx = 2'd2;
                end
            end else if (req[c0]) begin
                gnt_any = 1'b1;
                gnt_idx = c0;
            end else if (req[c1]) begin
                gnt_any = 1'b1;
                gnt_idx = c1;
            end else if (req[c2]) begin
                gnt_any = 1'b1;
                gnt_idx = c2;
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we     = we[gnt_idx];
        sel_addr   = addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
        sel_byteen = byteen[gnt_idx*4 +: 4];
        sel_wrdata = wrdata[gnt_idx*32 +: 32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 2'd2;
            locked_q <= 1'b0;
        end else begin
            if (gnt_any) begin
                last_q <= gnt_idx;
            end
            // Dropping dbg_lock releases the bus even if port 2 is idle.
            if (!dbg_lock) begin
                locked_q <= 1'b0;
            end else if (gnt_any && gnt_idx == 2'd2) begin
                locked_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rden   <= 1'b0;
            ram_wren   <= 1'b0;
            ram_addr   <= '0;
            ram_byteen <= 4'h0;
            ram_wrdata <= 32'h0;
        end else begin
            ram_rden <= gnt_any & ~sel_we;
            ram_wren <= gnt_any & sel_we;
            if (gnt_any) begin
                ram_addr   <= sel_addr;
                ram_byteen <= sel_byteen;
                ram_wrdata <= sel_wrdata;
            end
        end
    end

    // Tag pipe mirrors the RAM's one-cycle read latency behind the command register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1_vld  <= 1'b0;
            t1_port <= 2'd0;
            t2_vld  <= 1'b0;
            t2_port <= 2'd0;
        end else begin
            t1_vld  <= gnt_any & ~sel_we;
            t1_port <= gnt_idx;
            t2_vld  <= t1_vld;
            t2_port <= t1_port;
        end
    end

    always_comb begin
        rd_valid = 3'b000;
        if (t2_vld) begin
            rd_valid[t2_port] = 1'b1;
        end
        rd_data = ram_rddata;
    end

endmodule
